trigger_scheduler: RTL and testbench
====================================

Name: trigger_scheduler

Overview:
Sits between tlu_control and the Aurora channel receivers. Merges three trigger sources into one ordered stream of trigger records {source, trigger number}: TLU handshake triggers, a periodic internal pulser, and software pulses. Buffers records in a small FIFO and dispatches each one to exactly one enabled readout channel, chosen round-robin. Drives a hold line back toward the TLU busy path when buffering is nearly exhausted.

Parameters:
N_CH, 4, number of readout channels
FIFO_AW, 3, FIFO address width (depth = 2**FIFO_AW = 8)
TN_W, 32, trigger number width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  global enable; low blocks new FIFO writes, draining continues
src_mask  in  3  bit0 TLU, bit1 internal, bit2 software
int_period  in  32  internal trigger period in clk cycles; 0 disables
dispatch_timeout  in  16  max SEND wait in cycles; 0 = wait forever
tlu_ts  in  1  one-cycle strobe, trigger-number-valid from tlu_control
tlu_tn  in  TN_W  TLU trigger number, valid with tlu_ts
sw_trig  in  1  one-cycle software trigger pulse
ch_mask  in  N_CH  channel enables
ch_ready  in  N_CH  per-channel ready
trg_valid  out  1  record offered to selected channel
trg_ch_sel  out  N_CH  one-hot target channel
trg_src  out  2  00 TLU, 01 internal, 10 software
trg_num  out  TN_W  trigger number
busy_hold  out  1  hold request toward TLU busy logic
fifo_level  out  FIFO_AW+1  current occupancy
drop_cnt  out  16  dropped-record counter, saturating

Behaviour:
- Reset: all outputs 0, FIFO empty, pending flags clear, self_tn = 0, interval counter = 0, RR pointer = channel N_CH-1 (first grant goes to ch0), state IDLE.
- Ingest: at most one FIFO write per cycle. Priority is TLU > software > internal.
- TLU: tlu_ts && src_mask[0] && enable. Writes {00, tlu_tn} that cycle. If the FIFO is full, the record is dropped and drop_cnt increments. TLU records are never deferred.
- Software: sw_trig && src_mask[2] sets sw_pend. A second pulse while sw_pend is set is dropped and drop_cnt increments.
- Internal: the interval counter runs while enable && src_mask[1] && int_period != 0; otherwise it is held at 0. When the count reaches int_period-1 it wraps to 0 and sets int_pend. A fire while int_pend is already set increments drop_cnt.
- Pending writes: a pending flag writes {src, self_tn} when no higher-priority write occurs, the FIFO is not full and enable is high, then the flag clears. self_tn increments per self-trigger written and wraps at 2**32.
- enable low: pending flags are held, not dropped.
- busy_hold = !enable || fifo_level >= 2**FIFO_AW - 1. Registered, so it updates the cycle after the level changes.
- Dispatch FSM:
  - IDLE: FIFO non-empty -> ARB.
  - ARB: pop the head into the output registers. Select the first channel after the RR pointer with ch_mask set. If ch_mask == 0, discard the record, increment drop_cnt and go to IDLE; otherwise latch trg_ch_sel, update the pointer and go to SEND.
  - SEND: trg_valid = 1. A transfer occurs in any cycle with |(trg_ch_sel & ch_ready), then go to IDLE. The channel is fixed while valid is high; outputs are stable until transfer.
  - Timeout: wait counter reaches dispatch_timeout (nonzero) with no transfer -> drop the record, increment drop_cnt, go to IDLE.
- Latency: tlu_ts in cycle t with the scheduler idle and the FIFO empty -> trg_valid high in cycle t+3. Back-to-back records occupy three cycles each (IDLE, ARB, SEND) with an immediately ready channel.
- Simultaneous pop and write: allowed. fifo_level stays unchanged. A write to a full FIFO in the same cycle as a pop is accepted.
- drop_cnt saturates at 0xFFFF. Multiple drop events in one cycle add 1 each, saturating.
- Reset mid-transfer: trg_valid falls in the next cycle and the record is lost without counting.

Decomposition:
- Package trigger_sched_pkg holds:
  - source codes SRC_TLU = 2'b00, SRC_INT = 2'b01, SRC_SW = 2'b10;
  - FSM state encodings IDLE/ARB/SEND;
  - record width TN_W+2.
- Sub-module trig_fifo: synchronous FIFO with full/empty/level and first-word-fall-through read, parameterised by width and FIFO_AW.
- Round-robin select stays inline.

Test Plan:
- Single TLU trigger: tlu_ts with tlu_tn = 0x1234, ch_mask = 4'b1111, all ready -> 3 cycles later trg_valid = 1, trg_ch_sel = 0001, trg_src = 00, trg_num = 0x1234; one cycle high.
- Round-robin over masked channels: 4 TLU triggers tn = 1..4, ch_mask = 4'b1010 -> channel sequence 0010, 1000, 0010, 1000.
- Overflow: ch_ready = 0, timeout = 0, 10 TLU strobes -> fifo_level reaches 8 and busy_hold rises at level 7. One record is popped into SEND, so one more strobe fits: 9 records are buffered (8 in FIFO, 1 in SEND) and drop_cnt = 1.
- Collision: tlu_ts, sw_trig and an internal fire in the same cycle -> FIFO order TLU, then SW (self_tn 0), then INT (self_tn 1); drop_cnt = 0.
- Internal pulser: int_period = 5, src_mask = 010, 30 cycles -> 6 records, trg_num 0..5, spaced 5 cycles.
- Timeout: dispatch_timeout = 10, selected channel never ready -> trg_valid drops after 10 SEND cycles, drop_cnt = 1, the next record goes to the next channel.

Source files
------------

// File: rtl/trigger_sched_pkg.sv
`default_nettype none
// trigger_sched_pkg: source codes, dispatch states and record sizing shared by the trigger scheduler.
package trigger_sched_pkg;

  localparam logic [1:0] SRC_TLU = 2'b00;
  localparam logic [1:0] SRC_INT = 2'b01;
  localparam logic [1:0] SRC_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // A record is {source[1:0], trigger_number[TN_W-1:0]}.
  function automatic int rec_width(input int tn_w);
    return tn_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trig_fifo.sv
`default_nettype none
// trig_fifo: synchronous FIFO with first-word-fall-through read; a write to a full FIFO is accepted
// when a pop happens in the same cycle.
module trig_fifo #(
  parameter int WIDTH = 34,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/trigger_scheduler.sv
`default_nettype none
// trigger_scheduler: merges TLU, internal-pulser and software triggers into a FIFO of
// {source, number} records and hands each one to a single enabled channel, round-robin.
module trigger_scheduler
  import trigger_sched_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int FIFO_AW = 3,
  parameter int TN_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2:0]        src_mask,
  input  logic [31:0]       int_period,
  input  logic [15:0]       dispatch_timeout,
  input  logic              tlu_ts,
  input  logic [TN_W-1:0]   tlu_tn,
  input  logic              sw_trig,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [N_CH-1:0]   ch_ready,
  output logic              trg_valid,
  output logic [N_CH-1:0]   trg_ch_sel,
  output logic [1:0]        trg_src,
  output logic [TN_W-1:0]   trg_num,
  output logic              busy_hold,
  output logic [FIFO_AW:0]  fifo_level,
  output logic [15:0]       drop_cnt
);

  localparam int REC_W = rec_width(TN_W);
  localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  state_t            state;
  logic              sw_pend;
  logic              int_pend;
  logic [31:0]       int_cnt;
  logic [TN_W-1:0]   self_tn;
  logic [PW-1:0]     rr_ptr;
  logic [15:0]       wait_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic [REC_W-1:0]  fifo_rd_data;
  logic [REC_W-1:0]  wr_data;
  logic              wr_en;
  logic              pop;
  logic              room;
  logic              tlu_fire, tlu_drop;
  logic              self_ok, sw_wr, int_wr;
  logic              sw_req, sw_drop;
  logic              int_run, int_fire, int_drop;
  logic              arb_drop, to_drop, transfer;
  logic [2:0]        drop_inc;
  logic [16:0]       drop_sum;
  logic              sel_found;
  logic [PW-1:0]     sel_idx;
  int                idx;

  // Ingest: one write per cycle, TLU > software > internal; the pop in ARB frees a slot.
  assign pop      = (state == ST_ARB);
  assign room     = !fifo_full || pop;
  assign tlu_fire = tlu_ts && src_mask[0] && enable;
  assign tlu_drop = tlu_fire && !room;
  assign self_ok  = !tlu_fire && room && enable;
  assign sw_wr    = self_ok && sw_pend;
  assign int_wr   = self_ok && !sw_pend && int_pend;
  assign sw_req   = sw_trig && src_mask[2];
  assign sw_drop  = sw_req && sw_pend && !sw_wr;
  assign int_run  = enable && src_mask[1] && (int_period != 32'd0);
  assign int_fire = int_run && (int_cnt == int_period - 32'd1);
  assign int_drop = int_fire && int_pend && !int_wr;
  assign wr_en    = (tlu_fire && room) || sw_wr || int_wr;

  always_comb begin
    wr_data = {SRC_INT, self_tn};
    if (tlu_fire)   wr_data = {SRC_TLU, tlu_tn};
    else if (sw_wr) wr_data = {SRC_SW, self_tn};
  end

  // Walk downward so the last hit is the nearest enabled channel after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    idx       = 0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(rr_ptr) + i) % N_CH;
      if (ch_mask[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(idx);
      end
    end
  end

  assign transfer = (state == ST_SEND) && |(trg_ch_sel & ch_ready);
  assign arb_drop = pop && !sel_found;
  assign to_drop  = (state == ST_SEND) && !transfer && (dispatch_timeout != 16'd0) &&
                    (17'(wait_cnt) + 17'd1 == 17'(dispatch_timeout));
  assign drop_inc = 3'(tlu_drop) + 3'(sw_drop) + 3'(int_drop) + 3'(arb_drop) + 3'(to_drop);
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

  trig_fifo #(
    .WIDTH (REC_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_pend   <= 1'b0;
      int_pend  <= 1'b0;
      int_cnt   <= '0;
      self_tn   <= '0;
      drop_cnt  <= '0;
      busy_hold <= 1'b0;
    end else begin
      if (sw_req)     sw_pend <= 1'b1;
      else if (sw_wr) sw_pend <= 1'b0;
      if (int_fire)    int_pend <= 1'b1;
      else if (int_wr) int_pend <= 1'b0;
      int_cnt <= (!int_run || int_fire) ? 32'd0 : int_cnt + 32'd1;
      if (sw_wr || int_wr) self_tn <= self_tn + 1'b1;
      drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      busy_hold <= !enable || (fifo_level >= (FIFO_AW+1)'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      trg_valid  <= 1'b0;
      trg_ch_sel <= '0;
      trg_src    <= '0;
      trg_num    <= '0;
      rr_ptr     <= PW'(N_CH - 1);
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty) state <= ST_ARB;
        ST_ARB: begin
          trg_src <= fifo_rd_data[REC_W-1 -: 2];
          trg_num <= fifo_rd_data[TN_W-1:0];
          if (sel_found) begin
            trg_ch_sel <= N_CH'(1) << sel_idx;
            rr_ptr     <= sel_idx;
            trg_valid  <= 1'b1;
            wait_cnt   <= '0;
            state      <= ST_SEND;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (transfer || to_drop) begin
            trg_valid <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trigger_scheduler.sv
`default_nettype none
// tb_trigger_scheduler: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_trigger_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  src_mask;
  logic [31:0] int_period;
  logic [15:0] dispatch_timeout;
  logic        tlu_ts;
  logic [31:0] tlu_tn;
  logic        sw_trig;
  logic [3:0]  ch_mask;
  logic [3:0]  ch_ready;
  logic        trg_valid;
  logic [3:0]  trg_ch_sel;
  logic [1:0]  trg_src;
  logic [31:0] trg_num;
  logic        busy_hold;
  logic [3:0]  fifo_level;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  trigger_scheduler #(.N_CH(4), .FIFO_AW(3), .TN_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .src_mask(src_mask), .int_period(int_period),
    .dispatch_timeout(dispatch_timeout), .tlu_ts(tlu_ts), .tlu_tn(tlu_tn), .sw_trig(sw_trig),
    .ch_mask(ch_mask), .ch_ready(ch_ready), .trg_valid(trg_valid), .trg_ch_sel(trg_ch_sel),
    .trg_src(trg_src), .trg_num(trg_num), .busy_hold(busy_hold), .fifo_level(fifo_level),
    .drop_cnt(drop_cnt)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  // Reference model state
  logic [33:0] mq[$];
  bit          m_sw, m_int, m_busy, m_valid;
  int unsigned m_cnt;
  logic [31:0] m_tn;
  int          m_drop, m_phase, m_last, m_wait;
  logic [3:0]  m_sel;
  logic [1:0]  m_src;
  logic [31:0] m_num;

  // Observed transfers
  logic [3:0]  cap_sel[$];
  logic [1:0]  cap_src[$];
  logic [31:0] cap_num[$];
  int          cap_t[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int          lvl, drops, idx;
    bit          popping, room, tlu, sw_w, int_w, run, fire, found;
    logic [33:0] rec;
    if (rst) begin
      mq.delete();
      m_sw = 0; m_int = 0; m_busy = 0; m_valid = 0; m_cnt = 0; m_tn = '0;
      m_drop = 0; m_phase = 0; m_last = 3; m_wait = 0; m_sel = '0; m_src = '0; m_num = '0;
      return;
    end
    lvl     = mq.size();
    drops   = 0;
    popping = (m_phase == 1);
    room    = (lvl < 8) || popping;
    tlu     = tlu_ts && src_mask[0] && enable;
    sw_w    = !tlu && room && enable && m_sw;
    int_w   = !tlu && room && enable && !m_sw && m_int;
    run     = enable && src_mask[1] && (int_period != 0);
    fire    = run && (m_cnt == int_period - 1);
    m_busy  = !enable || (lvl >= 7);
    case (m_phase)
      0: if (lvl > 0) m_phase = 1;
      1: begin
        rec   = mq.pop_front();
        m_src = rec[33:32];
        m_num = rec[31:0];
        found = 0;
        for (int i = 1; i <= 4; i++) begin
          idx = (m_last + i) % 4;
          if (!found && ch_mask[idx]) begin
            found  = 1;
            m_last = idx;
          end
        end
        if (found) begin
          m_sel = 4'b0001 << m_last; m_valid = 1; m_wait = 0; m_phase = 2;
        end else begin
          drops++; m_phase = 0;
        end
      end
      default: begin
        if ((m_sel & ch_ready) != 4'b0) begin
          m_valid = 0; m_phase = 0;
        end else if (dispatch_timeout != 0 && m_wait + 1 == int'(dispatch_timeout)) begin
          drops++; m_valid = 0; m_phase = 0;
        end else begin
          m_wait++;
        end
      end
    endcase
    if (tlu) begin
      if (room) mq.push_back({2'b00, tlu_tn});
      else drops++;
    end
    if (sw_w)  begin mq.push_back({2'b10, m_tn}); m_tn++; end
    if (int_w) begin mq.push_back({2'b01, m_tn}); m_tn++; end
    if (sw_trig && src_mask[2]) begin
      if (m_sw && !sw_w) drops++;
      m_sw = 1;
    end else if (sw_w) m_sw = 0;
    if (fire) begin
      if (m_int && !int_w) drops++;
      m_int = 1;
    end else if (int_w) m_int = 0;
    m_cnt  = (!run || fire) ? 0 : m_cnt + 1;
    m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
  endtask

  task automatic check_all();
    chk("trg_valid", 64'(trg_valid), 64'(m_valid));
    if (m_valid) begin
      chk("trg_ch_sel", 64'(trg_ch_sel), 64'(m_sel));
      chk("trg_src", 64'(trg_src), 64'(m_src));
      chk("trg_num", 64'(trg_num), 64'(m_num));
    end
    chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
    chk("busy_hold", 64'(busy_hold), 64'(m_busy));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic tick();
    if (trg_valid && |(trg_ch_sel & ch_ready)) begin
      cap_sel.push_back(trg_ch_sel);
      cap_src.push_back(trg_src);
      cap_num.push_back(trg_num);
      cap_t.push_back(cyc);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic clear_caps();
    cap_sel.delete(); cap_src.delete(); cap_num.delete(); cap_t.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_caps();
  endtask

  task automatic strobe(input logic [31:0] tn);
    tlu_ts = 1'b1; tlu_tn = tn;
    tick();
    tlu_ts = 1'b0;
  endtask

  initial begin
    logic [3:0] rr_exp [4];
    int         n0;
    rr_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    rst = 1'b1; enable = 1'b0; src_mask = 3'b000; int_period = '0; dispatch_timeout = '0;
    tlu_ts = 1'b0; tlu_tn = '0; sw_trig = 1'b0; ch_mask = '0; ch_ready = '0;
    tick();
    chk("reset_valid", 64'(trg_valid), 64'd0);
    chk("reset_sel", 64'(trg_ch_sel), 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_busy", 64'(busy_hold), 64'd0);
    chk("reset_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // Single TLU trigger: valid three cycles after the strobe, for one cycle.
    enable = 1'b1; src_mask = 3'b001; ch_mask = 4'b1111; ch_ready = 4'b1111;
    tick();
    strobe(32'h1234);
    tick();
    chk("single_early", 64'(trg_valid), 64'd0);
    tick();
    chk("single_valid", 64'(trg_valid), 64'd1);
    chk("single_sel", 64'(trg_ch_sel), 64'b0001);
    chk("single_src", 64'(trg_src), 64'd0);
    chk("single_num", 64'(trg_num), 64'h1234);
    tick();
    chk("single_fall", 64'(trg_valid), 64'd0);

    // Round-robin over channels 1 and 3.
    clear_caps();
    ch_mask = 4'b1010;
    for (int i = 1; i <= 4; i++) strobe(32'(i));
    repeat (20) tick();
    chk("rr_count", 64'(cap_sel.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (cap_sel.size() > i) begin
        chk("rr_sel", 64'(cap_sel[i]), 64'(rr_exp[i]));
        chk("rr_num", 64'(cap_num[i]), 64'(i + 1));
      end
    end

    // Overflow: nothing ready, 10 strobes -> 8 buffered + 1 in SEND + 1 dropped.
    do_reset();
    enable = 1'b1; src_mask = 3'b001; ch_mask = 4'b1111; ch_ready = 4'b0000; dispatch_timeout = '0;
    for (int i = 0; i < 10; i++) strobe(32'(100 + i));
    repeat (2) tick();
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_drop", 64'(drop_cnt), 64'd1);
    chk("ovf_busy", 64'(busy_hold), 64'd1);
    chk("ovf_valid", 64'(trg_valid), 64'd1);
    ch_ready = 4'b1111;
    repeat (40) tick();
    chk("ovf_drained", 64'(fifo_level), 64'd0);
    chk("ovf_records", 64'(cap_sel.size()), 64'd9);

    // Collision of all three sources in one cycle.
    do_reset();
    enable = 1'b1; src_mask = 3'b111; int_period = 32'd3; ch_mask = 4'b1111; ch_ready = 4'b1111;
    tick();
    tick();
    sw_trig = 1'b1;
    strobe(32'h55);
    sw_trig = 1'b0; src_mask = 3'b001; int_period = '0;
    repeat (15) tick();
    chk("col_count", 64'(cap_sel.size()), 64'd3);
    if (cap_sel.size() == 3) begin
      chk("col_src0", 64'(cap_src[0]), 64'b00);
      chk("col_num0", 64'(cap_num[0]), 64'h55);
      chk("col_src1", 64'(cap_src[1]), 64'b10);
      chk("col_num1", 64'(cap_num[1]), 64'd0);
      chk("col_src2", 64'(cap_src[2]), 64'b01);
      chk("col_num2", 64'(cap_num[2]), 64'd1);
    end
    chk("col_drop", 64'(drop_cnt), 64'd0);

    // Internal pulser, period 5, for 30 cycles.
    do_reset();
    enable = 1'b1; src_mask = 3'b010; int_period = 32'd5;
    repeat (30) tick();
    src_mask = 3'b000;
    repeat (10) tick();
    chk("int_count", 64'(cap_num.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (cap_num.size() > i) begin
        chk("int_num", 64'(cap_num[i]), 64'(i));
        chk("int_src", 64'(cap_src[i]), 64'b01);
        if (i > 0) chk("int_spacing", 64'(cap_t[i] - cap_t[i-1]), 64'd5);
      end
    end

    // Dispatch timeout on a channel that never becomes ready.
    do_reset();
    enable = 1'b1; src_mask = 3'b001; int_period = '0; dispatch_timeout = 16'd10;
    ch_mask = 4'b1111; ch_ready = 4'b1110;
    n0 = 0;
    strobe(32'd7);
    strobe(32'd8);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (trg_valid && trg_ch_sel == 4'b0001) n0++;
    end
    chk("to_cycles", 64'(n0), 64'd10);
    chk("to_drop", 64'(drop_cnt), 64'd1);
    chk("to_count", 64'(cap_sel.size()), 64'd1);
    if (cap_sel.size() == 1) begin
      chk("to_next_sel", 64'(cap_sel[0]), 64'b0010);
      chk("to_next_num", 64'(cap_num[0]), 64'd8);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        enable           = ($urandom_range(0, 3) != 0);
        src_mask         = 3'($urandom_range(0, 7));
        int_period       = 32'($urandom_range(0, 9));
        dispatch_timeout = 16'($urandom_range(0, 5));
        ch_mask          = 4'($urandom_range(0, 15));
      end
      rst      = ($urandom_range(0, 499) == 0);
      tlu_ts   = ($urandom_range(0, 3) == 0);
      tlu_tn   = $urandom;
      sw_trig  = ($urandom_range(0, 7) == 0);
      ch_ready = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; tlu_ts = 1'b0; sw_trig = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
